// File: rtl/regfile_sb_pkg.sv
// Shared constants and types for the integer register file and its
// pending-load scoreboard.
package regfile_sb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [DATA_W-1:0] ZERO_WORD    = '0;
  localparam logic [ADDR_W-1:0] NOP_REG_ADDR = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-load scoreboard: one busy bit per register, set when a load issues,
// cleared by its write-back or a flush, and compared against both read ports.
module rf_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int ADDR_W = regfile_sb_pkg::ADDR_W,
  parameter int NREGS  = regfile_sb_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic              stall_o
);

  logic [NREGS-1:0] r_busy;
  logic             w_haz1;
  logic             w_haz2;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_busy <= '0;
    end else begin
      // NOTE: both lines may hit the same bit; the later non-blocking
      // assignment wins, so a new issue outranks the write-back clear.
      if (we_i)
        r_busy[waddr_i] <= DISABLE;
      if (issue_i && issue_addr_i != NOP_REG_ADDR)
        r_busy[issue_addr_i] <= ENABLE;
    end
  end

  // A write-back landing this cycle is forwarded by the bypass, so no stall.
  assign w_haz1 = re1_i && raddr1_i != NOP_REG_ADDR && r_busy[raddr1_i]
                  && !(we_i && waddr_i == raddr1_i);
  assign w_haz2 = re2_i && raddr2_i != NOP_REG_ADDR && r_busy[raddr2_i]
                  && !(we_i && waddr_i == raddr2_i);

  assign stall_o = !rst && (w_haz1 || w_haz2);

endmodule

// File: rtl/regfile_sb.sv
// Integer register file x0..x31 with two combinational read ports, write-back
// bypass, a pending-load hazard scoreboard and a saturating stall counter.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int          DATA_W        = regfile_sb_pkg::DATA_W,
  parameter int          ADDR_W        = regfile_sb_pkg::ADDR_W,
  parameter int          NREGS         = regfile_sb_pkg::NREGS,
  parameter logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [31:0]       stall_cnt_o
);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [31:0]       r_stall_cnt;
  logic              w_stall;

  function automatic logic [DATA_W-1:0] read_port(
    input logic              re,
    input logic [ADDR_W-1:0] ra,
    input logic              we,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic [DATA_W-1:0] stored
  );
    if (!re || ra == NOP_REG_ADDR)
      return ZERO_WORD;
    if (we && wa == ra)
      return wd;
    return stored;
  endfunction

  // NOTE: the storage array is reset explicitly because software expects
  // every register to read zero after reset, not just x0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= ZERO_WORD;
    end else if (we_i && waddr_i != NOP_REG_ADDR) begin
      r_regs[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = ZERO_WORD;
    rdata2_o = ZERO_WORD;
    if (!rst) begin
      rdata1_o = read_port(re1_i, raddr1_i, we_i, waddr_i, wdata_i, r_regs[raddr1_i]);
      rdata2_o = read_port(re2_i, raddr2_i, we_i, waddr_i, wdata_i, r_regs[raddr2_i]);
    end
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .issue_i      (issue_i),
    .issue_addr_i (issue_addr_i),
    .we_i         (we_i),
    .waddr_i      (waddr_i),
    .re1_i        (re1_i),
    .raddr1_i     (raddr1_i),
    .re2_i        (re2_i),
    .raddr2_i     (raddr2_i),
    .stall_o      (w_stall)
  );

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (w_stall && r_stall_cnt != STALL_CNT_MAX)
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_o     = w_stall;
  assign stall_cnt_o = r_stall_cnt;

endmodule
